fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Upstream neighbour of the immediate/instruction decode logic in the multi-cycle XM core.
- On request from the control unit, fetches one 16-bit instruction word from memory using a ready handshake and latches it into the instruction register (IR).
- IR contents feed the decoders; the block owns the program counter (PC).
- PC advances by 2 per completed fetch and can be loaded for branches.

Parameters:
- WORD, 16, data/address width in bits.
- RESET_PC, 16'h0000, PC value after reset; bit 0 must be 0.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- fetch_i  input  1  control unit requests the next instruction fetch.
- pcLoad_i  input  1  load PC with pcLoadVal_i (branch/jump).
- pcLoadVal_i  input  WORD  new PC value; bit 0 forced to 0 on load.
- memAddr_o  output  WORD  registered fetch address, stable while memRead_o=1.
- memRead_o  output  1  memory read request.
- memData_i  input  WORD  read data, valid when memReady_i=1.
- memReady_i  input  1  memory completes the read this cycle.
- instWord_o  output  WORD  instruction register contents.
- instValid_o  output  1  IR holds a freshly fetched, non-stale word.
- pc_o  output  WORD  current PC (address of the next fetch).
- busy_o  output  1  fetch in progress (state != IDLE).

Behaviour:
- Reset, asynchronous, active-low, effective immediately:
  - state=IDLE, pc_o=RESET_PC, memAddr_o=0, memRead_o=0, instWord_o=0, instValid_o=0, busy_o=0.
  - Reset mid-transaction drops memRead_o at once; the pending memory response is ignored after release.
- States: IDLE, WAIT, DISCARD.
- IDLE:
  - fetch_i=1: memAddr_o <= (pcLoad_i ? {pcLoadVal_i[WORD-1:1],1'b0} : pc_o), memRead_o <= 1, instValid_o <= 0, go to WAIT.
  - pcLoad_i=1 (with or without fetch_i): pc_o <= {pcLoadVal_i[WORD-1:1],1'b0} and instValid_o <= 0.
  - When pcLoad_i and fetch_i are both high, the fetch uses the loaded address.
- WAIT:
  - memRead_o and memAddr_o are held until memReady_i=1.
  - On memReady_i=1: instWord_o <= memData_i, instValid_o <= 1, pc_o <= memAddr_o + 2 (mod 2^WORD; 16'hFFFE wraps to 16'h0000), memRead_o <= 0, go to IDLE.
- pcLoad_i=1 in WAIT:
  - The bus transaction cannot be aborted.
  - pc_o <= loaded value; go to DISCARD (or straight to IDLE if memReady_i is also 1 that cycle).
  - In either case the returned data is not written to IR, instValid_o stays 0, and pc_o is not incremented; the load wins.
- DISCARD:
  - memRead_o stays high until memReady_i=1, then drops; go to IDLE with IR unchanged and instValid_o=0.
  - Further pcLoad_i in DISCARD updates pc_o.
- fetch_i outside IDLE is ignored; no queuing.
- busy_o = (state != IDLE), registered.
- Latency with a zero-wait memory (memReady_i high on the first request cycle):
  - fetch_i sampled at edge N.
  - memRead_o high in cycle N+1.
  - IR/instValid_o updated at edge N+2.
  - Minimum of 2 cycles per fetch.
- A memory wait of k extra cycles adds k cycles of latency.
- memData_i is don't-care when memReady_i=0.
- memReady_i while memRead_o=0 is ignored.

Test Plan:
- Reset release, fetch_i pulse, memReady_i high in the first request cycle, memData_i=16'h6A5B -> memAddr_o=0000 with memRead_o=1 for 1 cycle; instWord_o=6A5B; instValid_o=1; pc_o=0002.
- Three back-to-back fetches with 2-cycle memory wait each -> addresses 0000/0002/0004; memAddr_o stable during each wait; pc_o=0006 at end; busy_o high 3 cycles per fetch.
- pcLoad_i=1 with pcLoadVal_i=16'h1235 together with fetch_i in IDLE -> memAddr_o=1234; after data 16'hABCD, instWord_o=ABCD and pc_o=1236.
- pcLoad_i=16'h0400 during WAIT, memReady_i 2 cycles later with data 16'hDEAD -> IR unchanged; instValid_o=0; pc_o=0400; next fetch reads 0400.
- PC at 16'hFFFE, fetch completes -> pc_o=0000 (wrap).
- rst_n_i asserted low mid-WAIT (asynchronous, between edges) -> memRead_o, instValid_o and busy_o go to 0 immediately; pc_o=RESET_PC; a late memReady_i after release is ignored.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Memory read bus between the fetch unit (master) and instruction memory (slave).
//   memAddr  : fetch address, held stable while memRead is high
//   memRead  : read request
//   memData  : read data, meaningful only when memReady is high
//   memReady : memory completes the read this cycle
interface fetch_unit_if #(
  parameter int WORD = 16
);
  logic [WORD-1:0] memAddr;
  logic            memRead;
  logic [WORD-1:0] memData;
  logic            memReady;

  modport master (
    output memAddr,
    output memRead,
    input  memData,
    input  memReady
  );

  modport slave (
    input  memAddr,
    input  memRead,
    output memData,
    output memReady
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit for the multi-cycle XM core.
// Fetches one WORD-bit instruction per fetch_i request over a ready-handshake
// memory bus, latches it into the IR and owns the program counter.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   fetch_i          request the next instruction fetch (honoured only when idle)
//   pcLoad_i         load PC from pcLoadVal_i (bit 0 forced to 0)
//   pcLoadVal_i      branch/jump target
//   mem              memory bus (master side)
//   instWord_o       instruction register
//   instValid_o      IR holds a freshly fetched, non-stale word
//   pc_o             address of the next fetch
//   busy_o           fetch in progress
//
// state   | meaning
// IDLE    | no bus transaction outstanding
// WAIT    | read issued, data will be written to the IR
// DISCARD | read issued, PC was reloaded meanwhile; data will be dropped
module fetch_unit #(
  parameter int              WORD     = 16,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            fetch_i,
  input  logic            pcLoad_i,
  input  logic [WORD-1:0] pcLoadVal_i,
  fetch_unit_if.master    mem,
  output logic [WORD-1:0] instWord_o,
  output logic            instValid_o,
  output logic [WORD-1:0] pc_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic            read_q, read_d;
  logic [WORD-1:0] ir_q, ir_d;
  logic            valid_q, valid_d;
  logic            busy_q;
  logic [WORD-1:0] load_val;

  // Instructions are halfword aligned, so a loaded target always drops bit 0.
  assign load_val = {pcLoadVal_i[WORD-1:1], 1'b0};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      read_q  <= 1'b0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    read_d  = read_q;
    ir_d    = ir_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (pcLoad_i) begin
          pc_d    = load_val;
          valid_d = 1'b0;
        end
        if (fetch_i) begin
          addr_d  = pcLoad_i ? load_val : pc_q;
          read_d  = 1'b1;
          valid_d = 1'b0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A load during an outstanding read wins: the read still completes on
        // the bus but its data and the PC increment are thrown away.
        if (pcLoad_i) begin
          pc_d = load_val;
          if (mem.memReady) begin
            read_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else if (mem.memReady) begin
          ir_d    = mem.memData;
          valid_d = 1'b1;
          pc_d    = addr_q + WORD'(2);
          read_d  = 1'b0;
          state_d = IDLE;
        end
      end

      DISCARD: begin
        if (pcLoad_i) begin
          pc_d = load_val;
        end
        if (mem.memReady) begin
          read_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
      end
    endcase
  end

  assign mem.memAddr = addr_q;
  assign mem.memRead = read_q;
  assign instWord_o  = ir_q;
  assign instValid_o = valid_q;
  assign pc_o        = pc_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [15:0] inst_word;
  logic        inst_valid;
  logic [15:0] pc;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  bit check_en = 0;

  fetch_unit_if #(.WORD(16)) bus ();

  fetch_unit #(.WORD(16), .RESET_PC(16'h0000)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .fetch_i     (fetch),
    .pcLoad_i    (pc_load),
    .pcLoadVal_i (pc_load_val),
    .mem         (bus.master),
    .instWord_o  (inst_word),
    .instValid_o (inst_valid),
    .pc_o        (pc),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: one optional outstanding read, tagged stale when
  // the PC is reloaded while it is in flight.
  logic [15:0] m_pc, m_addr, m_ir;
  bit          m_req, m_stale, m_valid;

  task automatic model_reset();
    m_pc = 16'h0000; m_addr = 16'h0000; m_ir = 16'h0000;
    m_req = 0; m_stale = 0; m_valid = 0;
  endtask

  task automatic model_step(input logic f, input logic l, input logic [15:0] lv,
                            input logic r, input logic [15:0] d);
    logic [15:0] tgt;
    tgt = {lv[15:1], 1'b0};
    if (!m_req) begin
      if (l) begin m_pc = tgt; m_valid = 0; end
      if (f) begin
        m_addr = m_pc;
        m_req = 1; m_stale = 0; m_valid = 0;
      end
    end else begin
      if (l) begin m_pc = tgt; m_stale = 1; end
      if (r) begin
        m_req = 0;
        if (!m_stale) begin
          m_ir = d; m_valid = 1; m_pc = m_addr + 16'd2;
        end
      end
    end
  endtask

  task automatic pin(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      pin("memRead",   {15'd0, bus.memRead}, {15'd0, m_req});
      if (m_req) pin("memAddr", bus.memAddr, m_addr);
      pin("busy",      {15'd0, busy},        {15'd0, m_req});
      pin("instValid", {15'd0, inst_valid},  {15'd0, m_valid});
      pin("instWord",  inst_word,            m_ir);
      pin("pc",        pc,                   m_pc);
    end
  end

  task automatic cyc(input logic f, input logic l, input logic [15:0] lv,
                     input logic r, input logic [15:0] d);
    fetch = f; pc_load = l; pc_load_val = lv; bus.memReady = r; bus.memData = d;
    @(posedge clk);
    model_step(f, l, lv, r, d);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    fetch = 0; pc_load = 0; pc_load_val = 0; bus.memReady = 0; bus.memData = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  initial begin
    rst_n = 0;
    do_reset();
    check_en = 1;
    pin("rst_pc", pc, 16'h0000);
    pin("rst_valid", {15'd0, inst_valid}, 16'h0000);

    // single fetch, zero-wait memory
    cyc(1, 0, 0, 0, 16'h0000);
    pin("t1_read", {15'd0, bus.memRead}, 16'h0001);
    pin("t1_addr", bus.memAddr, 16'h0000);
    cyc(0, 0, 0, 1, 16'h6A5B);
    pin("t1_read_drop", {15'd0, bus.memRead}, 16'h0000);
    pin("t1_ir", inst_word, 16'h6A5B);
    pin("t1_valid", {15'd0, inst_valid}, 16'h0001);
    pin("t1_pc", pc, 16'h0002);

    // three back-to-back fetches, 2 wait cycles each; fetch_i in WAIT ignored
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 16'h0000);
      pin("t2_addr", bus.memAddr, 16'(2 * i));
      cyc(1, 0, 0, 0, 16'h0000);
      cyc(0, 0, 0, 0, 16'h0000);
      pin("t2_busy", {15'd0, busy}, 16'h0001);
      cyc(0, 0, 0, 1, 16'(16'h1000 + i));
      pin("t2_ir", inst_word, 16'(16'h1000 + i));
    end
    pin("t2_pc", pc, 16'h0006);

    // load together with fetch in IDLE
    cyc(1, 1, 16'h1235, 0, 16'h0000);
    pin("t3_addr", bus.memAddr, 16'h1234);
    cyc(0, 0, 0, 1, 16'hABCD);
    pin("t3_ir", inst_word, 16'hABCD);
    pin("t3_pc", pc, 16'h1236);

    // load during WAIT, data returned 2 cycles later is discarded
    cyc(1, 0, 0, 0, 16'h0000);
    cyc(0, 1, 16'h0400, 0, 16'h0000);
    cyc(0, 0, 0, 0, 16'h0000);
    pin("t4_busy", {15'd0, busy}, 16'h0001);
    cyc(0, 0, 0, 1, 16'hDEAD);
    pin("t4_ir", inst_word, 16'hABCD);
    pin("t4_valid", {15'd0, inst_valid}, 16'h0000);
    pin("t4_pc", pc, 16'h0400);
    cyc(1, 0, 0, 0, 16'h0000);
    pin("t4_addr", bus.memAddr, 16'h0400);
    // load in same cycle as ready: straight back to IDLE, data dropped
    cyc(0, 1, 16'h0801, 1, 16'h5555);
    pin("t4b_busy", {15'd0, busy}, 16'h0000);
    pin("t4b_pc", pc, 16'h0800);
    pin("t4b_ir", inst_word, 16'hABCD);
    // second load while in DISCARD updates PC
    cyc(1, 0, 0, 0, 16'h0000);
    cyc(0, 1, 16'h2000, 0, 16'h0000);
    cyc(0, 1, 16'h3000, 0, 16'h0000);
    cyc(0, 0, 0, 1, 16'h7777);
    pin("t4c_pc", pc, 16'h3000);
    // ready while idle is ignored
    cyc(0, 0, 0, 1, 16'h9999);
    pin("t4d_ir", inst_word, 16'hABCD);

    // wrap at top of address space
    cyc(0, 1, 16'hFFFE, 0, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000);
    pin("t5_addr", bus.memAddr, 16'hFFFE);
    cyc(0, 0, 0, 1, 16'h4321);
    pin("t5_pc", pc, 16'h0000);
    pin("t5_ir", inst_word, 16'h4321);

    // asynchronous reset mid-WAIT
    cyc(1, 1, 16'h0100, 0, 16'h0000);
    cyc(0, 0, 0, 0, 16'h0000);
    #1;
    rst_n = 0;
    model_reset();
    #1;
    pin("t6_read", {15'd0, bus.memRead}, 16'h0000);
    pin("t6_busy", {15'd0, busy}, 16'h0000);
    pin("t6_valid", {15'd0, inst_valid}, 16'h0000);
    pin("t6_pc", pc, 16'h0000);
    @(negedge clk);
    rst_n = 1;
    #1;
    cyc(0, 0, 0, 1, 16'hBEEF);
    pin("t6_late_ir", inst_word, 16'h0000);
    pin("t6_late_valid", {15'd0, inst_valid}, 16'h0000);
    cyc(0, 0, 0, 0, 16'h0000);

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
